// File: rtl/lsu_pkg.sv
// lsu_pkg: core pipeline state constants and LSU state encoding shared by the LSU slice
package lsu_pkg;
   localparam logic [2:0] CORE_REQUEST = 3'b011;
   localparam logic [2:0] CORE_UPDATE  = 3'b110;
   typedef enum logic [2:0] {
      LSU_IDLE       = 3'd0,
      LSU_REQUESTING = 3'd1,
      LSU_WAITING    = 3'd2,
      LSU_DONE       = 3'd3,
      LSU_FAULT      = 3'd4
   } lsu_state_t;
endpackage

// File: rtl/lsu_gen2_if.sv
// lsu_gen2_if: memory read/write handshake bundle between the LSU (master) and memory (slave)
// Ports: read channel valid/address/ready/data, write channel valid/address/data/ready
interface lsu_gen2_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
);
   logic                 mem_read_valid;
   logic [ADDR_BITS-1:0] mem_read_address;
   logic                 mem_read_ready;
   logic [DATA_BITS-1:0] mem_read_data;
   logic                 mem_write_valid;
   logic [ADDR_BITS-1:0] mem_write_address;
   logic [DATA_BITS-1:0] mem_write_data;
   logic                 mem_write_ready;
   modport master (
      output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
      input  mem_read_ready, mem_read_data, mem_write_ready
   );
   modport slave (
      input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
      output mem_read_ready, mem_read_data, mem_write_ready
   );
endinterface

// File: rtl/lsu_timeout_counter.sv
// lsu_timeout_counter: counts WAITING cycles and flags the cycle that reaches TIMEOUT_CYCLES
// Ports: clk, reset (sync, active-low), clear, count_en, expired (0 forever when TIMEOUT_CYCLES=0)
module lsu_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);
   localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   logic [W-1:0] cnt;
   // expires on the cycle whose count would make TIMEOUT_CYCLES
   assign expired = (TIMEOUT_CYCLES > 0) && count_en && (cnt == W'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge clk) begin
      if (!reset || clear) cnt <= '0;
      else if (count_en) cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/lsu_gen2.sv
// lsu_gen2: single-request load/store unit with valid/ready memory handshake, timeout and fault
// Ports: clk, reset (sync, active-low), enable, core_state, decode enables/offset, rs/rt,
//        mem (master side of lsu_gen2_if), lsu_state, lsu_out, lsu_fault
module lsu_gen2
   import lsu_pkg::*;
#(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [ADDR_BITS-1:0] decoded_mem_offset,
   input  logic [DATA_BITS-1:0] rs,
   input  logic [DATA_BITS-1:0] rt,
   lsu_gen2_if.master           mem,
   output logic [2:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_fault
);
   lsu_state_t           state;
   logic                 is_load;
   logic                 chan_ready;
   logic                 tmo_clear;
   logic                 tmo_count;
   logic                 tmo_expired;
   logic [ADDR_BITS-1:0] eff_addr;
   assign eff_addr   = ADDR_BITS'(rs) + decoded_mem_offset;
   assign chan_ready = is_load ? mem.mem_read_ready : mem.mem_write_ready;
   assign lsu_state  = state;
   assign tmo_count  = enable && state == LSU_WAITING && !chan_ready;
   assign tmo_clear  = enable && (state == LSU_REQUESTING ||
                       ((state == LSU_DONE || state == LSU_FAULT) && core_state == CORE_UPDATE));
   lsu_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
      .clk      (clk),
      .reset    (reset),
      .clear    (tmo_clear),
      .count_en (tmo_count),
      .expired  (tmo_expired)
   );
   always_ff @(posedge clk) begin
      if (!reset) begin
         state                 <= LSU_IDLE;
         is_load               <= 1'b0;
         lsu_out               <= '0;
         lsu_fault             <= 1'b0;
         mem.mem_read_valid    <= 1'b0;
         mem.mem_read_address  <= '0;
         mem.mem_write_valid   <= 1'b0;
         mem.mem_write_address <= '0;
         mem.mem_write_data    <= '0;
      end else if (enable) begin
         case (state)
            LSU_IDLE:
               if (core_state == CORE_REQUEST) begin
                  if (decoded_mem_read_enable && decoded_mem_write_enable) begin
                     state     <= LSU_FAULT;
                     lsu_fault <= 1'b1;
                  end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
                     state   <= LSU_REQUESTING;
                     is_load <= decoded_mem_read_enable;
                  end
               end
            LSU_REQUESTING: begin
               if (is_load) begin
                  mem.mem_read_valid   <= 1'b1;
                  mem.mem_read_address <= eff_addr;
               end else begin
                  mem.mem_write_valid   <= 1'b1;
                  mem.mem_write_address <= eff_addr;
                  mem.mem_write_data    <= rt;
               end
               state <= LSU_WAITING;
            end
            LSU_WAITING:
               // ready is tested first so a response on the expiry edge still succeeds
               if (chan_ready) begin
                  mem.mem_read_valid  <= 1'b0;
                  mem.mem_write_valid <= 1'b0;
                  if (is_load) lsu_out <= mem.mem_read_data;
                  state <= LSU_DONE;
               end else if (tmo_expired) begin
                  mem.mem_read_valid  <= 1'b0;
                  mem.mem_write_valid <= 1'b0;
                  lsu_fault           <= 1'b1;
                  state               <= LSU_FAULT;
               end
            default:
               if (core_state == CORE_UPDATE) begin
                  state     <= LSU_IDLE;
                  lsu_fault <= 1'b0;
               end
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_gen2.sv
// tb_lsu_gen2: directed vector table plus hand sequences for timeout, illegal decode, enable and reset
module tb_lsu_gen2;
   import lsu_pkg::*;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [2:0] core_state = 3'd0;
   logic       rd = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] off = 8'd0;
   logic [7:0] rs = 8'd0;
   logic [7:0] rt = 8'd0;
   logic [2:0] lsu_state;
   logic [7:0] lsu_out;
   logic       lsu_fault;
   int         n_chk = 0;
   int         n_fail = 0;
   lsu_gen2_if #(.ADDR_BITS(8), .DATA_BITS(8)) mem ();
   lsu_gen2 #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(4)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .enable                   (enable),
      .core_state               (core_state),
      .decoded_mem_read_enable  (rd),
      .decoded_mem_write_enable (wr),
      .decoded_mem_offset       (off),
      .rs                       (rs),
      .rt                       (rt),
      .mem                      (mem.master),
      .lsu_state                (lsu_state),
      .lsu_out                  (lsu_out),
      .lsu_fault                (lsu_fault)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic       ld;
      logic [7:0] rs, off, rt, rdata, eaddr, eout;
      int         w;
   } vec_t;
   vec_t v[5];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic run_vec(input vec_t t, input int idx);
      string p;
      p = $sformatf("v%0d", idx);
      rs = t.rs; off = t.off; rt = t.rt; rd = t.ld; wr = !t.ld;
      mem.mem_read_data  = t.rdata;
      // inactive channel's ready is held high to show it is ignored
      mem.mem_read_ready  = t.ld ? (t.w == 0) : 1'b1;
      mem.mem_write_ready = t.ld ? 1'b1 : (t.w == 0);
      core_state = CORE_REQUEST;
      tick();
      chk({p, "_req_state"}, 32'(lsu_state), 1);
      core_state = 3'd0;
      tick();
      chk({p, "_wait_state"}, 32'(lsu_state), 2);
      for (int i = 0; i <= t.w; i++) begin
         chk({p, "_valid"}, t.ld ? mem.mem_read_valid : mem.mem_write_valid, 1);
         chk({p, "_other_valid"}, t.ld ? mem.mem_write_valid : mem.mem_read_valid, 0);
         chk({p, "_addr"}, t.ld ? mem.mem_read_address : mem.mem_write_address, 32'(t.eaddr));
         if (!t.ld) chk({p, "_wdata"}, 32'(mem.mem_write_data), 32'(t.rt));
         if (i == t.w) begin
            if (t.ld) mem.mem_read_ready = 1'b1;
            else mem.mem_write_ready = 1'b1;
         end
         tick();
         if (i < t.w) chk({p, "_still_wait"}, 32'(lsu_state), 2);
      end
      chk({p, "_done_state"}, 32'(lsu_state), 3);
      chk({p, "_done_valid"}, 32'(mem.mem_read_valid | mem.mem_write_valid), 0);
      chk({p, "_lsu_out"}, 32'(lsu_out), 32'(t.eout));
      mem.mem_read_ready = 1'b0; mem.mem_write_ready = 1'b0;
      core_state = CORE_UPDATE;
      tick();
      chk({p, "_idle"}, 32'(lsu_state), 0);
      core_state = 3'd0; rd = 1'b0; wr = 1'b0;
   endtask
   initial begin
      v[0] = '{ld:1'b1, rs:8'h10, off:8'h05, rt:8'h00, rdata:8'hAB, eaddr:8'h15, eout:8'hAB, w:2};
      v[1] = '{ld:1'b0, rs:8'hF0, off:8'h20, rt:8'h5A, rdata:8'h77, eaddr:8'h10, eout:8'hAB, w:1};
      v[2] = '{ld:1'b1, rs:8'hFF, off:8'h01, rt:8'h00, rdata:8'h3C, eaddr:8'h00, eout:8'h3C, w:0};
      v[3] = '{ld:1'b1, rs:8'h80, off:8'h7F, rt:8'h00, rdata:8'h00, eaddr:8'hFF, eout:8'h00, w:3};
      v[4] = '{ld:1'b0, rs:8'h01, off:8'h02, rt:8'hC3, rdata:8'h11, eaddr:8'h03, eout:8'h00, w:3};
      mem.mem_read_ready = 1'b0; mem.mem_write_ready = 1'b0; mem.mem_read_data = 8'h00;
      tick(); tick();
      chk("rst_state", 32'(lsu_state), 0);
      chk("rst_out", 32'(lsu_out), 0);
      chk("rst_fault", 32'(lsu_fault), 0);
      chk("rst_valids", 32'({mem.mem_read_valid, mem.mem_write_valid}), 0);
      chk("rst_addrs", 32'({mem.mem_read_address, mem.mem_write_address, mem.mem_write_data}), 0);
      reset = 1'b1;
      tick();
      rd = 1'b1; core_state = CORE_REQUEST;
      tick();
      chk("disabled_idle", 32'(lsu_state), 0);
      rd = 1'b0; core_state = 3'd0; enable = 1'b1;
      for (int i = 0; i < 5; i++) run_vec(v[i], i);
      // timeout: no ready for 4 WAITING cycles
      rs = 8'h20; off = 8'h00; rd = 1'b1; core_state = CORE_REQUEST;
      tick();
      core_state = 3'd0;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("tmo_waiting", 32'(lsu_state), 2);
         chk("tmo_valid_held", 32'(mem.mem_read_valid), 1);
      end
      tick();
      chk("tmo_state", 32'(lsu_state), 4);
      chk("tmo_valid_drop", 32'(mem.mem_read_valid), 0);
      chk("tmo_fault", 32'(lsu_fault), 1);
      chk("tmo_out_kept", 32'(lsu_out), 0);
      tick();
      chk("tmo_hold_fault", 32'(lsu_state), 4);
      core_state = CORE_UPDATE;
      tick();
      chk("tmo_clear_state", 32'(lsu_state), 0);
      chk("tmo_clear_fault", 32'(lsu_fault), 0);
      // illegal decode
      core_state = CORE_REQUEST; rd = 1'b1; wr = 1'b1;
      tick();
      chk("ill_state", 32'(lsu_state), 4);
      chk("ill_fault", 32'(lsu_fault), 1);
      core_state = 3'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ill_no_valid", 32'({mem.mem_read_valid, mem.mem_write_valid}), 0);
      end
      core_state = CORE_UPDATE;
      tick();
      chk("ill_idle", 32'(lsu_state), 0);
      chk("ill_fault_clr", 32'(lsu_fault), 0);
      // enable=0 while WAITING freezes everything, even with ready high
      core_state = CORE_REQUEST; rd = 1'b1; wr = 1'b0; rs = 8'h40; off = 8'h01;
      mem.mem_read_data = 8'h99;
      tick();
      core_state = 3'd0;
      tick();
      enable = 1'b0; mem.mem_read_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("en0_state", 32'(lsu_state), 2);
         chk("en0_valid", 32'(mem.mem_read_valid), 1);
         chk("en0_addr", 32'(mem.mem_read_address), 32'h41);
      end
      enable = 1'b1;
      tick();
      chk("en1_done", 32'(lsu_state), 3);
      chk("en1_out", 32'(lsu_out), 32'h99);
      mem.mem_read_ready = 1'b0; core_state = CORE_UPDATE;
      tick();
      core_state = 3'd0; rd = 1'b0;
      // reset while a store is waiting, with enable low
      core_state = CORE_REQUEST; wr = 1'b1; rs = 8'h07; off = 8'h08; rt = 8'hEE;
      tick();
      core_state = 3'd0;
      tick();
      chk("rstw_valid_pre", 32'(mem.mem_write_valid), 1);
      chk("rstw_data_pre", 32'(mem.mem_write_data), 32'hEE);
      reset = 1'b0; enable = 1'b0;
      tick();
      chk("rstw_state", 32'(lsu_state), 0);
      chk("rstw_valid", 32'(mem.mem_write_valid), 0);
      chk("rstw_addr", 32'(mem.mem_write_address), 0);
      chk("rstw_data", 32'(mem.mem_write_data), 0);
      chk("rstw_out", 32'(lsu_out), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lsu_gen2.md
LSU_GEN2 -- requirements
Module: lsu_gen2

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, register/memory data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAITING cycles before fault; 0 disables timeout.
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port enable  input  1  thread active; when 0, all state and outputs hold.
REQ-007 SHALL have port core_state  input  3  core pipeline state.
REQ-008 SHALL have ports decoded_mem_read_enable, decoded_mem_write_enable  input  1 each  LDR / STR decode.
REQ-009 SHALL have port decoded_mem_offset  input  ADDR_BITS  unsigned address offset.
REQ-010 SHALL have ports rs, rt  input  DATA_BITS each  base address / store data.
REQ-011 SHALL have ports mem_read_valid output 1, mem_read_address output ADDR_BITS, mem_read_ready input 1, mem_read_data input DATA_BITS.
REQ-012 SHALL have ports mem_write_valid output 1, mem_write_address output ADDR_BITS, mem_write_data output DATA_BITS, mem_write_ready input 1.
REQ-013 SHALL have ports lsu_state output 3, lsu_out output DATA_BITS, lsu_fault output 1  status, load result, fault flag.

Function
REQ-014 SHALL implement states IDLE=0, REQUESTING=1, WAITING=2, DONE=3, FAULT=4 on lsu_state.
REQ-015 SHALL leave IDLE for REQUESTING only when enable=1, core_state=REQUEST (3'b011), and exactly one of the decode enables is 1.
REQ-016 SHALL, when both decode enables are 1 in IDLE with core_state=REQUEST, go directly to FAULT with lsu_fault=1 and issue no memory request.
REQ-017 SHALL compute effective address = (rs truncated or zero-extended to ADDR_BITS) + decoded_mem_offset, modulo 2^ADDR_BITS (wrap, no carry out).
REQ-018 SHALL, in REQUESTING, drive the address onto the selected channel's address output, assert that channel's valid, latch rt to mem_write_data for stores, move to WAITING, one cycle.
REQ-019 SHALL hold valid, address and write data stable throughout WAITING until ready is sampled 1.
REQ-020 SHALL, in WAITING on ready=1, deassert valid on the same edge, capture mem_read_data into lsu_out for loads (lsu_out unchanged for stores), go to DONE.
REQ-021 SHALL count WAITING cycles; at TIMEOUT_CYCLES cycles without ready (TIMEOUT_CYCLES>0), deassert valid, set lsu_fault=1, go to FAULT, lsu_out unchanged.
REQ-022 SHALL treat ready arriving on the same edge the counter expires as success (ready wins).
REQ-023 SHALL return from DONE or FAULT to IDLE only when core_state=UPDATE (3'b110), clearing lsu_fault and the counter on that edge.
REQ-024 SHALL ignore ready inputs outside WAITING and ignore the inactive channel's ready.
REQ-025 SHALL, with enable=0 in any state, freeze state, counter and all outputs (valid remains asserted if in WAITING).
REQ-026 SHALL give minimum load latency of 3 cycles from the REQUEST edge to DONE when ready is already 1.

Reset
REQ-027 SHALL, on reset=0 at a clock edge, set lsu_state=IDLE, counter=0, lsu_out=0, lsu_fault=0, both valids=0, both addresses=0, mem_write_data=0, regardless of enable.
REQ-028 SHALL abandon any in-flight request on reset, deasserting valid on that edge.

Structure
REQ-029 SHALL take core-state constants (REQUEST, UPDATE) and the lsu_state enumeration from a shared package, lsu_pkg.
REQ-030 SHALL implement the timeout counter as one sub-module, lsu_timeout_counter (clear, count-enable, expired output, width $clog2(TIMEOUT_CYCLES+1)).

Verification
REQ-031 SHALL cover load: rs=0x10, offset=0x05, memory returns 0xAB after 2 wait cycles -> mem_read_address=0x15, lsu_out=0xAB, DONE, IDLE after UPDATE.
REQ-032 SHALL cover store wrap: rs=0xF0, offset=0x20, rt=0x5A -> mem_write_address=0x10, mem_write_data=0x5A stable until ready, lsu_out unchanged.
REQ-033 SHALL cover timeout: TIMEOUT_CYCLES=4, ready held 0 -> valid drops after 4 WAITING cycles, lsu_fault=1, FAULT, cleared on UPDATE.
REQ-034 SHALL cover illegal decode: both enables 1 at REQUEST -> FAULT next cycle, no valid ever asserted.
REQ-035 SHALL cover reset mid-WAITING and enable=0 mid-WAITING: reset -> all outputs zero next edge; enable=0 -> state/valid held, resumes on enable=1.
